// File: rtl/i2c_sb_pkg.sv
// Shared constants and types for the iCE40UP I2C system-bus sequencer.
// Register map, command codes and the per-direction step ROM live here.
package i2c_sb_pkg;

    localparam logic [3:0] OFF_CR1   = 4'h8;
    localparam logic [3:0] OFF_CMDR  = 4'h9;
    localparam logic [3:0] OFF_BRLSB = 4'hA;
    localparam logic [3:0] OFF_BRMSB = 4'hB;
    localparam logic [3:0] OFF_SR    = 4'hC;
    localparam logic [3:0] OFF_TXDR  = 4'hD;
    localparam logic [3:0] OFF_RXDR  = 4'hE;

    localparam logic [7:0] CMD_STA_WR  = 8'h94;
    localparam logic [7:0] CMD_WR      = 8'h14;
    localparam logic [7:0] CMD_RD_NACK = 8'h2C;
    localparam logic [7:0] CMD_STO     = 8'h44;
    localparam logic [7:0] CR1_EN      = 8'h80;

    localparam int SR_TIP   = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_RARC  = 5;
    localparam int SR_TRRDY = 2;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_SB_WR, ST_SB_RD, ST_POLL, ST_ABORT, ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_WR, OP_RX, OP_POLL_TX, OP_POLL_RX, OP_POLL_IDLE, OP_END
    } op_t;

    typedef enum logic [2:0] {
        SRC_DEVW, SRC_DEVR, SRC_REG, SRC_WDATA,
        SRC_STA_WR, SRC_WR, SRC_RD_NACK, SRC_STO
    } src_t;

    typedef struct packed {
        op_t  op;
        src_t src;
    } step_t;

    // Steps 0..5 (address + register byte) are shared by both directions.
    function automatic step_t step_rom(input logic rd, input logic [3:0] idx);
        step_t s;
        s = step_t'{OP_END, SRC_STO};
        case (idx)
            4'd0:  s = step_t'{OP_WR, SRC_DEVW};
            4'd1:  s = step_t'{OP_WR, SRC_STA_WR};
            4'd2:  s = step_t'{OP_POLL_TX, SRC_STO};
            4'd3:  s = step_t'{OP_WR, SRC_REG};
            4'd4:  s = step_t'{OP_WR, SRC_WR};
            4'd5:  s = step_t'{OP_POLL_TX, SRC_STO};
            4'd6:  s = rd ? step_t'{OP_WR, SRC_DEVR} : step_t'{OP_WR, SRC_WDATA};
            4'd7:  s = rd ? step_t'{OP_WR, SRC_STA_WR} : step_t'{OP_WR, SRC_WR};
            4'd8:  s = step_t'{OP_POLL_TX, SRC_STO};
            4'd9:  s = rd ? step_t'{OP_WR, SRC_RD_NACK} : step_t'{OP_WR, SRC_STO};
            4'd10: s = rd ? step_t'{OP_POLL_RX, SRC_STO} : step_t'{OP_POLL_IDLE, SRC_STO};
            4'd11: s = rd ? step_t'{OP_WR, SRC_STO} : step_t'{OP_END, SRC_STO};
            4'd12: s = rd ? step_t'{OP_RX, SRC_STO} : step_t'{OP_END, SRC_STO};
            4'd13: s = rd ? step_t'{OP_POLL_IDLE, SRC_STO} : step_t'{OP_END, SRC_STO};
            default: s = step_t'{OP_END, SRC_STO};
        endcase
        return s;
    endfunction

    function automatic logic [7:0] src_data(input src_t s, input logic [6:0] dev,
                                            input logic [7:0] rg, input logic [7:0] wd);
        logic [7:0] d;
        case (s)
            SRC_DEVW:    d = {dev, 1'b0};
            SRC_DEVR:    d = {dev, 1'b1};
            SRC_REG:     d = rg;
            SRC_WDATA:   d = wd;
            SRC_STA_WR:  d = CMD_STA_WR;
            SRC_WR:      d = CMD_WR;
            SRC_RD_NACK: d = CMD_RD_NACK;
            default:     d = CMD_STO;
        endcase
        return d;
    endfunction

    function automatic state_t op_state(input op_t op);
        state_t s;
        case (op)
            OP_WR:   s = ST_SB_WR;
            OP_RX:   s = ST_SB_RD;
            OP_END:  s = ST_RESP;
            default: s = ST_POLL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2c_sb_access.sv
// Single system-bus access: registered strobe/address/data held until ack,
// with a saturating wait counter that abandons the access on timeout.
module i2c_sb_access #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] adr,
    input  logic [7:0] dat,
    output logic       done,
    output logic       tmo,
    output logic [7:0] rdata,
    output logic       sb_stb_o,
    output logic       sb_we_o,
    output logic [7:0] sb_adr_o,
    output logic [7:0] sb_dat_o,
    input  logic [7:0] sb_dat_i,
    input  logic       sb_ack_i
);

    logic [15:0] cnt_q;

    assign done  = sb_stb_o && sb_ack_i;
    assign tmo   = sb_stb_o && !sb_ack_i && (cnt_q >= TIMEOUT_CYC - 16'd1);
    assign rdata = sb_dat_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_stb_o <= 1'b0;
            sb_we_o  <= 1'b0;
            sb_adr_o <= 8'h00;
            sb_dat_o <= 8'h00;
            cnt_q    <= 16'd0;
        end else if (start) begin
            sb_stb_o <= 1'b1;
            sb_we_o  <= we;
            sb_adr_o <= adr;
            sb_dat_o <= dat;
            cnt_q    <= 16'd0;
        end else if (done || tmo) begin
            sb_stb_o <= 1'b0;
        end else if (sb_stb_o && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/i2c_sb_sequencer.sv
// Turns single-register I2C write/read requests into the ordered SB
// accesses of the iCE40UP I2C hard IP (init, TXDR/CMDR, SR polling, RXDR).
module i2c_sb_sequencer
    import i2c_sb_pkg::*;
#(
    parameter logic [3:0]  BUS_ADDR74  = 4'b0001,
    parameter logic [9:0]  PRESCALE    = 10'd60,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic       sb_clk_i,
    input  logic       sb_rst_ni,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_err,
    output logic [7:0] rsp_rdata,
    output logic       sb_stb_o,
    output logic       sb_we_o,
    output logic [7:0] sb_adr_o,
    output logic [7:0] sb_dat_o,
    input  logic [7:0] sb_dat_i,
    input  logic       sb_ack_i
);

    state_t      state_q;
    logic [3:0]  step_q;
    logic        rd_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic        abort_q;
    logic        start_q;
    logic [15:0] poll_cnt;

    logic        acc_done;
    logic        acc_tmo;
    logic [7:0]  acc_rdata;
    logic        acc_we;
    logic [3:0]  acc_off;
    logic [7:0]  acc_dat;
    step_t       cur;
    step_t       nxt;
    logic        cond_ok;
    logic        poll_to;

    // The access descriptor is derived from the state entered together with start_q.
    always_comb begin
        cur     = step_rom(rd_q, step_q);
        nxt     = step_rom(rd_q, step_q + 4'd1);
        acc_we  = 1'b0;
        acc_off = OFF_SR;
        acc_dat = 8'h00;
        case (state_q)
            ST_INIT: begin
                acc_we = 1'b1;
                case (step_q)
                    4'd0: begin
                        acc_off = OFF_CR1;
                        acc_dat = CR1_EN;
                    end
                    4'd1: begin
                        acc_off = OFF_BRLSB;
                        acc_dat = PRESCALE[7:0];
                    end
                    default: begin
                        acc_off = OFF_BRMSB;
                        acc_dat = {6'b0, PRESCALE[9:8]};
                    end
                endcase
            end
            ST_ABORT: begin
                acc_we  = 1'b1;
                acc_off = OFF_CMDR;
                acc_dat = CMD_STO;
            end
            ST_SB_WR: begin
                acc_we  = 1'b1;
                acc_off = (cur.src >= SRC_STA_WR) ? OFF_CMDR : OFF_TXDR;
                acc_dat = src_data(cur.src, dev_q, reg_q, wdata_q);
            end
            ST_SB_RD: acc_off = OFF_RXDR;
            default: ;
        endcase
        if (abort_q || cur.op == OP_POLL_IDLE) begin
            cond_ok = !acc_rdata[SR_BUSY];
        end else begin
            cond_ok = acc_rdata[SR_TRRDY];
        end
        poll_to = (poll_cnt >= TIMEOUT_CYC);
    end

    i2c_sb_access #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_access (
        .clk      (sb_clk_i),
        .rst_n    (sb_rst_ni),
        .start    (start_q),
        .we       (acc_we),
        .adr      ({BUS_ADDR74, acc_off}),
        .dat      (acc_dat),
        .done     (acc_done),
        .tmo      (acc_tmo),
        .rdata    (acc_rdata),
        .sb_stb_o (sb_stb_o),
        .sb_we_o  (sb_we_o),
        .sb_adr_o (sb_adr_o),
        .sb_dat_o (sb_dat_o),
        .sb_dat_i (sb_dat_i),
        .sb_ack_i (sb_ack_i)
    );

    // start_q resets high so the first CR1 write launches right after reset.
    always_ff @(posedge sb_clk_i or negedge sb_rst_ni) begin
        if (!sb_rst_ni) begin
            state_q   <= ST_INIT;
            step_q    <= 4'd0;
            start_q   <= 1'b1;
            rd_q      <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            abort_q   <= 1'b0;
            poll_cnt  <= 16'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= ERR_OK;
            rsp_rdata <= 8'h00;
        end else begin
            start_q   <= 1'b0;
            rsp_valid <= 1'b0;
            if (state_q == ST_POLL && poll_cnt != 16'hFFFF) begin
                poll_cnt <= poll_cnt + 16'd1;
            end
            case (state_q)
                ST_INIT: begin
                    if (acc_tmo || (acc_done && step_q == 4'd2)) begin
                        state_q   <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else if (acc_done) begin
                        step_q  <= step_q + 4'd1;
                        start_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        rd_q      <= req_rd;
                        dev_q     <= req_dev;
                        reg_q     <= req_reg;
                        wdata_q   <= req_wdata;
                        step_q    <= 4'd0;
                        abort_q   <= 1'b0;
                        state_q   <= ST_SB_WR;
                        start_q   <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                ST_SB_WR, ST_SB_RD, ST_ABORT, ST_POLL: begin
                    if (acc_tmo || (state_q == ST_POLL && acc_done && !cond_ok && poll_to)) begin
                        state_q   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_TMO;
                    end else if (state_q == ST_POLL && acc_done && !cond_ok) begin
                        start_q <= 1'b1;
                    end else if (state_q == ST_POLL && acc_done && abort_q) begin
                        state_q   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_NACK;
                    end else if (state_q == ST_ABORT && acc_done) begin
                        state_q  <= ST_POLL;
                        abort_q  <= 1'b1;
                        poll_cnt <= 16'd0;
                        start_q  <= 1'b1;
                    end else if (state_q == ST_POLL && acc_done &&
                                 cur.op == OP_POLL_TX && acc_rdata[SR_RARC]) begin
                        state_q <= ST_ABORT;
                        start_q <= 1'b1;
                    end else if (acc_done) begin
                        if (state_q == ST_SB_RD) begin
                            rsp_rdata <= acc_rdata;
                        end
                        step_q <= step_q + 4'd1;
                        if (nxt.op == OP_END) begin
                            state_q   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= ERR_OK;
                        end else begin
                            state_q  <= op_state(nxt.op);
                            start_q  <= 1'b1;
                            poll_cnt <= 16'd0;
                        end
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_sb_sequencer.sv
// Bench for i2c_sb_sequencer: hard-IP bus model plus scoreboards of
// expected SB writes and expected responses.
module tb_i2c_sb_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rd = 1'b0;
    logic [6:0] req_dev = 7'd0;
    logic [7:0] req_reg = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [7:0] rsp_rdata;
    logic       sb_stb_o;
    logic       sb_we_o;
    logic [7:0] sb_adr_o;
    logic [7:0] sb_dat_o;
    logic [7:0] sb_dat_i = 8'h00;
    logic       sb_ack_i = 1'b0;

    int         errs = 0;
    int         checks = 0;
    int         rsp_cnt = 0;
    logic [15:0] wq[$];
    logic [10:0] rq[$];
    bit         hang = 0;
    bit         nack = 0;
    bit         m_pend = 0;
    bit         m_stop = 0;
    logic [7:0] slave_byte = 8'h3C;

    always #5 clk = ~clk;

    i2c_sb_sequencer #(
        .TIMEOUT_CYC(16'd100)
    ) dut (
        .sb_clk_i  (clk),
        .sb_rst_ni (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_dev   (req_dev),
        .req_reg   (req_reg),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .sb_stb_o  (sb_stb_o),
        .sb_we_o   (sb_we_o),
        .sb_adr_o  (sb_adr_o),
        .sb_dat_o  (sb_dat_o),
        .sb_dat_i  (sb_dat_i),
        .sb_ack_i  (sb_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hard-IP model: a CMDR write makes the next SR read show TRRDY=0/BUSY=1;
    // after that TRRDY=1, and BUSY clears only once a STOP has been issued.
    initial begin
        int wcnt;
        bit after_ack;
        logic [15:0] e;
        wcnt = 0;
        after_ack = 0;
        forever begin
            @(negedge clk);
            if (after_ack) chk("stb_drop", sb_stb_o, 1'b0);
            after_ack = 0;
            sb_ack_i = 1'b0;
            if (!sb_stb_o || hang) begin
                wcnt = $urandom_range(0, 2);
            end else if (wcnt > 0) begin
                wcnt--;
            end else begin
                if (sb_we_o) begin
                    e = (wq.size() > 0) ? wq.pop_front() : 16'hFFFF;
                    chk("sb_wr", {sb_adr_o, sb_dat_o}, e);
                    if (sb_adr_o == 8'h19) begin
                        m_pend = 1;
                        m_stop = (sb_dat_o == 8'h44);
                    end
                end else if (sb_adr_o == 8'h1E) begin
                    sb_dat_i = slave_byte;
                end else begin
                    chk("sb_rd_adr", sb_adr_o, 8'h1C);
                    sb_dat_i = {1'b0, m_pend || !m_stop, nack, 2'b00, !m_pend, 2'b00};
                    m_pend = 0;
                end
                sb_ack_i = 1'b1;
                after_ack = 1;
            end
        end
    end

    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                e = (rq.size() > 0) ? rq.pop_front() : 11'h7FF;
                chk("rsp_err", rsp_err, e[9:8]);
                if (e[10]) chk("rsp_rdata", rsp_rdata, e[7:0]);
                rsp_cnt++;
            end
        end
    end

    task automatic push_init();
        wq.push_back(16'h1880);
        wq.push_back(16'h1A3C);
        wq.push_back(16'h1B00);
    endtask

    task automatic push_wr(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        wq.push_back({8'h1D, dev, 1'b0});
        wq.push_back(16'h1994);
        wq.push_back({8'h1D, rg});
        wq.push_back(16'h1914);
        wq.push_back({8'h1D, wd});
        wq.push_back(16'h1914);
        wq.push_back(16'h1944);
        rq.push_back({1'b0, 2'b00, 8'h00});
    endtask

    task automatic push_rd(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] sb);
        wq.push_back({8'h1D, dev, 1'b0});
        wq.push_back(16'h1994);
        wq.push_back({8'h1D, rg});
        wq.push_back(16'h1914);
        wq.push_back({8'h1D, dev, 1'b1});
        wq.push_back(16'h1994);
        wq.push_back(16'h192C);
        wq.push_back(16'h1944);
        rq.push_back({1'b1, 2'b00, sb});
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, req_ready, 1'b1);
    endtask

    task automatic send(input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
        wait_ready("req_ready");
        req_rd = rd;
        req_dev = dev;
        req_reg = rg;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n0);
        int n;
        n = 0;
        while (rsp_cnt == n0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", rsp_cnt != n0, 1'b1);
        chk("wq_drained", wq.size(), 0);
    endtask

    initial begin
        int n0;
        int n;
        int cnt;
        #12;
        chk("rst_sb", {sb_stb_o, sb_we_o, sb_adr_o, sb_dat_o}, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata, req_ready}, 0);
        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init_ready");
        chk("init_wq", wq.size(), 0);

        n0 = rsp_cnt;
        push_wr(7'h24, 8'h10, 8'hA5);
        send(1'b0, 7'h24, 8'h10, 8'hA5);
        wait_rsp(n0);

        n0 = rsp_cnt;
        slave_byte = 8'h3C;
        push_rd(7'h24, 8'h05, 8'h3C);
        send(1'b1, 7'h24, 8'h05, 8'h00);
        wait_rsp(n0);

        n0 = rsp_cnt;
        slave_byte = 8'hC3;
        push_rd(7'h50, 8'hFF, 8'hC3);
        send(1'b1, 7'h50, 8'hFF, 8'h11);
        wait_rsp(n0);

        n0 = rsp_cnt;
        nack = 1;
        wq.push_back(16'h1D48);
        wq.push_back(16'h1994);
        wq.push_back(16'h1944);
        rq.push_back({1'b0, 2'b01, 8'h00});
        send(1'b0, 7'h24, 8'h10, 8'hA5);
        wait_rsp(n0);
        nack = 0;

        n0 = rsp_cnt;
        hang = 1;
        rq.push_back({1'b0, 2'b10, 8'h00});
        send(1'b0, 7'h24, 8'h33, 8'h44);
        n = 0;
        while (!sb_stb_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        cnt = 0;
        while (sb_stb_o && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        chk("tmo_stb_cycles", cnt, 100);
        wait_rsp(n0);
        hang = 0;

        n0 = rsp_cnt;
        push_wr(7'h3A, 8'h7E, 8'h5C);
        send(1'b0, 7'h3A, 8'h7E, 8'h5C);
        wait_rsp(n0);

        slave_byte = 8'h3C;
        push_rd(7'h24, 8'h05, 8'h3C);
        send(1'b1, 7'h24, 8'h05, 8'h00);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sb", {sb_stb_o, sb_we_o, sb_adr_o, sb_dat_o}, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata, req_ready}, 0);
        wq.delete();
        rq.delete();
        m_pend = 0;
        m_stop = 0;
        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reinit_ready");
        chk("reinit_wq", wq.size(), 0);

        n0 = rsp_cnt;
        slave_byte = 8'h96;
        push_rd(7'h0F, 8'h80, 8'h96);
        send(1'b1, 7'h0F, 8'h80, 8'h00);
        wait_rsp(n0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
